// File: rtl/booth_radix4_seq_multiplier.sv
// ----------------------------------------------------------------------------
// booth_radix4_seq_multiplier
//
// Sequential radix-4 Booth multiplier that retires one Booth digit per clock.
// Handles signed or unsigned operands and uses a start/busy/done handshake.
// Its result feeds the HI/LO product registers of the CPU datapath.
//
// Parameters:
//   WIDTH        operand width in bits (even, >= 4)
//
// Ports:
//   clock        system clock, rising-edge active
//   reset        synchronous active-high reset; aborts any operation
//   start        request a multiply (sampled only while idle)
//   signed_mode  1 = two's-complement operands, 0 = unsigned (sampled with start)
//   m            multiplicand (sampled with start)
//   q            multiplier (sampled with start)
//   busy         high from the accepted start through the done cycle
//   done         one-cycle pulse; out is valid in that cycle
//   out          2*WIDTH-bit product, held until the next accepted start
//
// Optional feature (compile-time macro):
//   BOOTH_EARLY_TERM_EN  finish as soon as every remaining Booth digit is zero
// ----------------------------------------------------------------------------
module booth_radix4_seq_multiplier #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   m,
    input  logic [WIDTH-1:0]   q,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] out
);

    localparam int unsigned EW = WIDTH + 2;      // extended operand width
    localparam int unsigned QW = WIDTH + 3;      // multiplier register incl. appended bit
    localparam int unsigned AW = 2 * WIDTH + 4;  // accumulator width
    localparam int unsigned PW = 2 * WIDTH;      // product width
    localparam int unsigned N  = WIDTH / 2 + 1;  // Booth digits per operation
    localparam int unsigned CW = $clog2(N + 1);  // counter must also hold N

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [EW-1:0] mcand;
    logic [QW-1:0] mplier;
    logic [AW-1:0] acc;
    logic [CW-1:0] count;

    logic [EW-1:0] m_ext_c;
    logic [EW-1:0] q_ext_c;
    logic [AW-1:0] m_wide_c;
    logic [AW-1:0] pp_c;
    logic [AW-1:0] pp_shift_c;
    logic          early_c;

    // Operand extension to WIDTH+2 bits so the unsigned worst case stays positive.
    always_comb begin
        m_ext_c = {2'b00, m};
        q_ext_c = {2'b00, q};
        if (signed_mode) begin
            m_ext_c = {{2{m[WIDTH-1]}}, m};
            q_ext_c = {{2{q[WIDTH-1]}}, q};
        end
    end

    // Booth recoding of the low three multiplier bits and partial-product alignment.
    always_comb begin
        m_wide_c = {{(AW - EW){mcand[EW-1]}}, mcand};
        pp_c     = '0;
        case (mplier[2:0])
            3'b001, 3'b010: pp_c = m_wide_c;
            3'b011:         pp_c = m_wide_c << 1;
            3'b100:         pp_c = -(m_wide_c << 1);
            3'b101, 3'b110: pp_c = -m_wide_c;
            default:        pp_c = '0;
        endcase
        pp_shift_c = pp_c << {count, 1'b0};
    end

    // Bits [QW-1:2] feed every digit after the current one; a uniform run of
    // 0s or 1s there recodes to all-zero digits, so nothing is left to add.
`ifdef BOOTH_EARLY_TERM_EN
    assign early_c = (&mplier[QW-1:2]) | ~(|mplier[QW-1:2]);
`else
    assign early_c = 1'b0;
`endif

    // Control FSM and datapath. A count of N marks the wrap-up cycle before DONE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            out    <= '0;
            acc    <= '0;
            count  <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand  <= m_ext_c;
                        mplier <= {q_ext_c, 1'b0};
                        acc    <= '0;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (count == CW'(N)) begin
                        out   <= acc[PW-1:0];
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        acc    <= acc + pp_shift_c;
                        // Arithmetic shift keeps the upper bits equal to the sign.
                        mplier <= {{2{mplier[QW-1]}}, mplier[QW-1:2]};
                        count  <= early_c ? CW'(N) : count + CW'(1);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
